// File: rtl/sub_serial.sv
`default_nettype none
// ============================================================================
// Module   : sub_serial
// Purpose  : Bit-serial two's-complement subtractor, D = A - B, LSB first,
//            one bit per clock, valid/ready handshakes on input and output.
//            d[WIDTH] carries the borrow-out, d[WIDTH-1:0] the modular
//            difference.
// Options  : SUB_SERIAL_SAT_EN - when defined, a final borrow forces the
//            WIDTH-bit difference to zero (unsigned saturation); the borrow
//            bit is still reported and latency is unchanged.
// Revision : 1.0 - initial release
// ============================================================================
module sub_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   d
);

    // Counter only has to reach WIDTH-1; WIDTH >= 2 keeps CNT_W >= 1.
    localparam int             CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q,     state_d;
    // The minuend register doubles as the result register: each cycle its
    // LSB is consumed and the new difference bit enters at the MSB, so after
    // WIDTH shifts it holds the complete difference.
    logic [WIDTH-1:0] ad_sh_q,     ad_sh_d;
    logic [WIDTH-1:0] b_sh_q,      b_sh_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             br_q,        br_d;
    logic [WIDTH:0]   d_q,         d_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q,  in_ready_d;

    logic             w_ai;
    logic             w_bi;
    logic             w_di;
    logic             w_br_next;
    logic [WIDTH-1:0] w_res_shift;
    logic [WIDTH-1:0] w_res_final;

    // One full-subtractor bit slice operating on the current operand LSBs.
    always_comb begin
        w_ai        = ad_sh_q[0];
        w_bi        = b_sh_q[0];
        w_di        = w_ai ^ w_bi ^ br_q;
        w_br_next   = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & br_q);
        w_res_shift = {w_di, ad_sh_q[WIDTH-1:1]};
    end

`ifdef SUB_SERIAL_SAT_EN
    // Unsigned saturation: an underflowing difference clamps to zero.
    assign w_res_final = w_br_next ? '0 : w_res_shift;
`else
    assign w_res_final = w_res_shift;
`endif

    // Next-state and next-output computation for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d     = state_q;
        ad_sh_d     = ad_sh_q;
        b_sh_d      = b_sh_q;
        cnt_d       = cnt_q;
        br_d        = br_q;
        d_d         = d_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    ad_sh_d    = a;
                    b_sh_d     = b;
                    br_d       = 1'b0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                ad_sh_d = w_res_shift;
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                br_d    = w_br_next;
                cnt_d   = cnt_q + C_ONE;
                if (cnt_q == C_LAST) begin
                    cnt_d       = '0;
                    d_d         = {w_br_next, w_res_final};
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                // Returning to IDLE first guarantees no accept on the
                // output-handshake edge.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ad_sh_q     <= '0;
            b_sh_q      <= '0;
            cnt_q       <= '0;
            br_q        <= 1'b0;
            d_q         <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            ad_sh_q     <= ad_sh_d;
            b_sh_q      <= b_sh_d;
            cnt_q       <= cnt_d;
            br_q        <= br_d;
            d_q         <= d_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign d         = d_q;

endmodule
`default_nettype wire
